// File: rtl/lab_defs.sv
// Shared definitions for the lab stimulus/capture blocks: FSM encodings and
// the default debounce interval (10 ms at 50 MHz).
package lab_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } seq_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_SETTLE_CYCLES   = 4;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-interval counter; emits a single-cycle
// press pulse when the button is accepted high, re-arms only after a stable low.
module button_debouncer
  import lab_defs::*;
#(
  parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt measures how long the synced input has disagreed with the accepted level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/function_input_sequencer.sv
// Drives a,b,c for a 3-input function block (manual step or full sweep per
// press), captures f_in after a settle delay and assembles the 8-entry truth table.
module function_input_sequencer
  import lab_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn,
  input  logic       sweep,
  input  logic       f_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [7:0] table_out,
  output logic       table_valid,
  output logic       busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic          rst_meta;
  logic          rst_n;
  logic          press;
  seq_state_t    state;
  logic          mode;
  logic [2:0]    abc;
  logic [7:0]    cap_mask;
  logic [CW-1:0] cnt;

  // Reset asserts immediately but is released on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  button_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(rst_n),
    .btn    (btn),
    .press  (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= 1'b0;
      abc         <= 3'd0;
      cnt         <= '0;
      table_out   <= 8'd0;
      cap_mask    <= 8'd0;
      table_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      table_valid <= &cap_mask;
      case (state)
        IDLE: begin
          if (press) begin
            mode  <= sweep;
            cnt   <= '0;
            state <= SETTLE;
            busy  <= 1'b1;
            if (sweep) begin
              abc       <= 3'd0;
              table_out <= 8'd0;
              cap_mask  <= 8'd0;
            end else begin
              abc <= abc + 3'd1;
            end
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: begin
          table_out[abc] <= f_in;
          cap_mask[abc]  <= 1'b1;
          // A finished sweep parks on abc=7 rather than wrapping
          if (mode && (abc != 3'd7)) begin
            abc   <= abc + 3'd1;
            state <= SETTLE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {a, b, c} = abc;

endmodule

// File: tb/tb_function_input_sequencer.sv
// Bench for function_input_sequencer: vector table, timing/corner sequences and
// randomized press traffic checked against a truth-table level model.
module tb_function_input_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn = 1'b0;
  logic       sweep = 1'b0;
  logic       f_in;
  logic       a, b, c;
  logic [7:0] table_out;
  logic       table_valid;
  logic       busy;
  logic [7:0] ftab = 8'h4F;
  logic       busy_seen = 1'b0;

  int checks = 0;
  int failures = 0;

  function_input_sequencer #(
    .DEBOUNCE_CYCLES(8),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .sweep      (sweep),
    .f_in       (f_in),
    .a          (a),
    .b          (b),
    .c          (c),
    .table_out  (table_out),
    .table_valid(table_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The function block under test: a programmable truth table indexed by {a,b,c}
  assign f_in = ftab[{a, b, c}];

  always @(posedge clk) if (busy) busy_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    bit         sw;
    int         high;
    logic [7:0] ft;
    logic [2:0] exp_abc;
    logic [7:0] exp_tab;
    bit         exp_valid;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int high, input int low);
    btn = 1'b1;
    tick(high);
    btn = 1'b0;
    tick(low);
  endtask

  task automatic do_reset();
    btn = 1'b0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
  endtask

  int         k;
  int         bl;
  bit         sw;
  int         kind;
  logic [7:0] ft;
  logic [7:0] mtab;
  logic [7:0] mmask;
  logic [2:0] mabc;

  initial begin
    //  sw high  ftab   abc   table  valid busy
    vecs[0] = '{1'b0, 20, 8'h4F, 3'd1, 8'h02, 1'b0, 1'b1};
    vecs[1] = '{1'b0,  5, 8'h4F, 3'd1, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{1'b0,  7, 8'h4F, 3'd1, 8'h02, 1'b0, 1'b0};
    vecs[3] = '{1'b0,  8, 8'h4F, 3'd2, 8'h06, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 20, 8'h4F, 3'd3, 8'h0E, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 20, 8'h4F, 3'd7, 8'h4F, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 20, 8'h00, 3'd0, 8'h4E, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 20, 8'h00, 3'd1, 8'h4C, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 20, 8'hA5, 3'd7, 8'hA5, 1'b1, 1'b1};

    // Reset values, then a timed sweep: valid 41 cycles after the press, busy 40
    reset_n = 1'b0;
    tick(2);
    check("reset_abc", {a, b, c}, 0);
    check("reset_table", table_out, 0);
    check("reset_valid", table_valid, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
    tick(4);
    ftab = 8'h4F;
    sweep = 1'b1;
    btn = 1'b1;
    k = 0;
    while (!busy && k < 60) begin tick(1); k++; end
    check("sweep_start", busy, 1);
    k = 0;
    bl = 0;
    while (!table_valid && k < 200) begin
      if (busy) bl++;
      if (k == 5) btn = 1'b0;
      tick(1);
      k++;
    end
    btn = 1'b0;
    check("sweep_valid_latency", k, 41);
    check("sweep_busy_len", bl, 40);
    check("sweep_table", table_out, 8'h4F);
    check("sweep_abc", {a, b, c}, 7);
    check("sweep_busy_end", busy, 0);
    tick(20);

    // New sweep from a valid table with a dropped press and a mode toggle mid-sweep
    ftab = 8'h4F;
    sweep = 1'b1;
    busy_seen = 1'b0;
    btn = 1'b1;
    k = 0;
    while (!busy && k < 60) begin tick(1); k++; end
    check("resweep_start", busy, 1);
    check("resweep_valid_k0", table_valid, 1);
    tick(1);
    check("resweep_valid_cleared", table_valid, 0);
    tick(3);
    btn = 1'b0;
    sweep = 1'b0;
    tick(12);
    press(14, 70);
    check("drop_table", table_out, 8'h4F);
    check("drop_abc", {a, b, c}, 7);
    check("drop_valid", table_valid, 1);
    check("drop_busy", busy, 0);

    // Manual latency: busy for SETTLE+1 cycles, capture of entry 1
    do_reset();
    sweep = 1'b0;
    btn = 1'b1;
    k = 0;
    while (!busy && k < 60) begin tick(1); k++; end
    check("manual_start", busy, 1);
    bl = 0;
    k = 0;
    while (busy && k < 60) begin bl++; tick(1); k++; end
    btn = 1'b0;
    check("manual_busy_len", bl, 5);
    check("manual_table", table_out, 8'h02);
    tick(20);

    // Repeated 5/5 glitches never produce a press
    do_reset();
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) press(5, 5);
    tick(20);
    check("glitch_busy", busy_seen, 0);
    check("glitch_abc", {a, b, c}, 0);

    // Eight manual presses fill the table, wrapping abc back to 0
    do_reset();
    ftab = 8'h4F;
    sweep = 1'b0;
    for (int i = 0; i < 7; i++) press(15, 20);
    check("manual7_valid", table_valid, 0);
    press(15, 20);
    check("manual8_valid", table_valid, 1);
    check("manual8_abc", {a, b, c}, 0);
    check("manual8_table", table_out, 8'h4F);

    // Vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ftab = vecs[i].ft;
      sweep = vecs[i].sw;
      busy_seen = 1'b0;
      press(vecs[i].high, 70);
      check($sformatf("vec%0d_abc", i), {a, b, c}, vecs[i].exp_abc);
      check($sformatf("vec%0d_table", i), table_out, vecs[i].exp_tab);
      check($sformatf("vec%0d_valid", i), table_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_busy_seen", i), busy_seen, vecs[i].exp_busy);
    end

    // Reset mid-sweep at abc=5
    ftab = 8'h4F;
    sweep = 1'b1;
    press(14, 0);
    k = 0;
    while ({a, b, c} != 3'd5 && k < 100) begin tick(1); k++; end
    check("midreset_reach_abc5", {a, b, c}, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_abc", {a, b, c}, 0);
    check("midreset_table", table_out, 0);
    check("midreset_valid", table_valid, 0);
    check("midreset_busy", busy, 0);
    busy_seen = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(40);
    check("postreset_busy_seen", busy_seen, 0);
    check("postreset_table", table_out, 0);
    check("postreset_abc", {a, b, c}, 0);

    // Randomized presses against a truth-table model
    do_reset();
    mtab = 8'h00;
    mmask = 8'h00;
    mabc = 3'd0;
    for (int n = 0; n < 30; n++) begin
      sw = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      ft = 8'($urandom);
      ftab = ft;
      sweep = sw;
      busy_seen = 1'b0;
      if (kind == 0) begin
        press($urandom_range(1, 7), 70);
      end else if (kind == 3 && sw) begin
        press(14, 12);
        sweep = ~sw;
        press($urandom_range(10, 20), 70);
      end else begin
        press($urandom_range(12, 25), 70);
      end
      if (kind != 0) begin
        if (sw) begin
          mtab = ft;
          mmask = 8'hFF;
          mabc = 3'd7;
        end else begin
          mabc = mabc + 3'd1;
          mtab[mabc] = ft[mabc];
          mmask[mabc] = 1'b1;
        end
      end
      check($sformatf("rand%0d_abc", n), {a, b, c}, mabc);
      check($sformatf("rand%0d_table", n), table_out, mtab);
      check($sformatf("rand%0d_valid", n), table_valid, &mmask);
      check($sformatf("rand%0d_busy_seen", n), busy_seen, (kind != 0));
      check($sformatf("rand%0d_idle", n), busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
